// File: rtl/risc5_intctl_if.sv
// CPU/IO-bus side bundle of the interrupt controller: irq lines, CPU handshake, register port.
// master drives requests/strobes, slave (the controller) drives req/vec/rdata.
interface risc5_intctl_if #(
    parameter int NIRQ = 8,
    parameter int PCW  = 22
);
    logic [NIRQ-1:0] irq;
    logic            cpu_ie;
    logic            ack;
    logic            rti;
    logic            req;
    logic [PCW-1:0]  vec;
    logic            wr;
    logic            rd;
    logic [1:0]      adr;
    logic [31:0]     wdata;
    logic [31:0]     rdata;

    modport master (
        output irq, cpu_ie, ack, rti, wr, rd, adr, wdata,
        input  req, vec, rdata
    );

    modport slave (
        input  irq, cpu_ie, ack, rti, wr, rd, adr, wdata,
        output req, vec, rdata
    );
endinterface

// File: rtl/risc5_intctl.sv
// Vectored, nesting interrupt controller: irq edge-to-req latency 3 clocks, level 2 clocks.
// No backpressure: req is held until ack; ack/rti/register writes act at the sampling edge.
module risc5_intctl #(
    parameter int NIRQ       = 8,
    parameter int PCW        = 22,
    parameter int VEC_BASE   = 1,
    parameter int VEC_STRIDE = 2
) (
    input  logic           clk,
    input  logic           rst,
    risc5_intctl_if.slave  bus
);
    typedef logic [NIRQ-1:0] chan_t;

    chan_t s1, s2, s3;
    chan_t pend_e, en, mode, isr;
    chan_t edge_det, pend, top_oh, below_top, elig, id_oh, pend_clr, isr_n;
    logic [4:0] top, id;
    logic ack_fire, pend_wr;
    logic unused_ok;

    assign edge_det = s2 & ~s3;
    assign pend     = (mode & s2) | (~mode & pend_e);

    // Lowest set bit of ISR; minus one gives the mask of strictly higher priorities
    // (all ones when nothing is in service).
    assign top_oh    = isr & (~isr + chan_t'(1));
    assign below_top = top_oh - chan_t'(1);
    assign elig      = pend & en & below_top;
    assign id_oh     = elig & (~elig + chan_t'(1));

    always_comb begin
        top = '0;
        id  = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (isr[i])
                top = 5'(i);
            if (elig[i])
                id = 5'(i);
        end
    end

    assign bus.req  = bus.cpu_ie & (|elig);
    assign bus.vec  = PCW'(VEC_BASE) + PCW'(id) * PCW'(VEC_STRIDE);
    assign ack_fire = bus.ack & bus.req;
    assign pend_wr  = bus.wr && (bus.adr == 2'd1);

    assign pend_clr = (pend_wr ? bus.wdata[NIRQ-1:0] : '0) | (ack_fire ? id_oh : '0);
    // rti retires the innermost level before ack pushes the new one.
    assign isr_n    = (isr & ~(bus.rti ? top_oh : '0)) | (ack_fire ? id_oh : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            s3     <= '0;
            pend_e <= '0;
            isr    <= '0;
            en     <= '0;
            mode   <= '0;
        end else begin
            s1     <= bus.irq;
            s2     <= s1;
            s3     <= s2;
            pend_e <= edge_det | (pend_e & ~pend_clr);
            isr    <= isr_n;
            if (bus.wr && (bus.adr == 2'd0))
                en <= bus.wdata[NIRQ-1:0];
            if (bus.wr && (bus.adr == 2'd2))
                mode <= bus.wdata[NIRQ-1:0];
        end
    end

    always_comb begin
        bus.rdata = '0;
        case (bus.adr)
            2'd0: bus.rdata = 32'(en);
            2'd1: bus.rdata = 32'(pend);
            2'd2: bus.rdata = 32'(mode);
            default: begin
                bus.rdata[31]   = |isr;
                bus.rdata[16]   = bus.req;
                bus.rdata[12:8] = id;
                bus.rdata[4:0]  = top;
            end
        endcase
    end

    // Reads are side-effect free, so rd and the unused wdata bits are not needed.
    assign unused_ok = ^{bus.rd, bus.wdata};
endmodule

// File: tb/tb_risc5_intctl.sv
// Randomized bench for risc5_intctl against a stack-based behavioural model of nesting.
module tb_risc5_intctl;
    localparam int NIRQ = 8;
    localparam int PCW  = 22;
    localparam int VB   = 1;
    localparam int VS   = 2;

    logic clk;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    risc5_intctl_if #(.NIRQ(NIRQ), .PCW(PCW)) intf ();

    risc5_intctl #(.NIRQ(NIRQ), .PCW(PCW), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: synchroniser samples, edge latches, registers, and the
    // in-service channels as a stack of accepted ids (innermost last).
    bit [NIRQ-1:0] m_s1, m_s2, m_s3, m_pe, m_en, m_mode;
    int stk[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_pend(int i);
        return m_mode[i] ? m_s2[i] : m_pe[i];
    endfunction

    function automatic void m_eval(output int id, output bit any);
        int lim = (stk.size() != 0) ? stk[$] : NIRQ;
        id  = 0;
        any = 1'b0;
        for (int i = 0; i < lim; i++)
            if (m_pend(i) && m_en[i] && !any) begin
                id  = i;
                any = 1'b1;
            end
    endfunction

    function automatic logic [31:0] m_rdata(logic [1:0] a);
        int id;
        bit any;
        logic [31:0] r = '0;
        logic [NIRQ-1:0] p;
        m_eval(id, any);
        for (int i = 0; i < NIRQ; i++) p[i] = m_pend(i);
        case (a)
            2'd0: r = 32'(m_en);
            2'd1: r = 32'(p);
            2'd2: r = 32'(m_mode);
            default: begin
                r[31]   = stk.size() != 0;
                r[4:0]  = (stk.size() != 0) ? 5'(stk[$]) : 5'd0;
                r[12:8] = 5'(id);
                r[16]   = intf.cpu_ie && any;
            end
        endcase
        return r;
    endfunction

    function automatic logic [63:0] m_vec(int id);
        return 64'((longint'(VB) + longint'(id) * VS) % (longint'(1) << PCW));
    endfunction

    task automatic m_reset();
        m_s1 = '0; m_s2 = '0; m_s3 = '0; m_pe = '0; m_en = '0; m_mode = '0;
        stk.delete();
    endtask

    task automatic m_step();
        int id;
        bit any, fire;
        bit [NIRQ-1:0] edg;
        m_eval(id, any);
        fire = intf.ack && intf.cpu_ie && any;
        edg  = m_s2 & ~m_s3;
        for (int i = 0; i < NIRQ; i++) begin
            if (edg[i])
                m_pe[i] = 1'b1;
            else if ((intf.wr && intf.adr == 2'd1 && intf.wdata[i]) || (fire && id == i))
                m_pe[i] = 1'b0;
        end
        if (intf.rti && stk.size() != 0) void'(stk.pop_back());
        if (fire) stk.push_back(id);
        if (intf.wr && intf.adr == 2'd0) m_en = intf.wdata[NIRQ-1:0];
        if (intf.wr && intf.adr == 2'd2) m_mode = intf.wdata[NIRQ-1:0];
        m_s3 = m_s2;
        m_s2 = m_s1;
        m_s1 = intf.irq;
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic cycle();
        int id;
        bit any;
        #2;
        m_eval(id, any);
        check("req", 64'(intf.req), 64'(intf.cpu_ie && any));
        check("vec", 64'(intf.vec), m_vec(id));
        check("rdata", 64'(intf.rdata), 64'(m_rdata(intf.adr)));
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        intf.ack = 1'b0; intf.rti = 1'b0; intf.wr = 1'b0; intf.rd = 1'b0;
        intf.adr = 2'd0; intf.wdata = '0;
    endtask

    initial begin
        rst = 1'b1;
        intf.irq = '0;
        intf.cpu_ie = 1'b0;
        idle_inputs();
        m_reset();
        #3;
        check("rst_req", 64'(intf.req), 64'd0);
        check("rst_vec", 64'(intf.vec), 64'(VB));
        for (int a = 0; a < 4; a++) begin
            intf.adr = 2'(a);
            #1;
            check("rst_rdata", 64'(intf.rdata), 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Single edge source: enable all, pulse irq[3] for two clocks.
        intf.wr = 1'b1; intf.adr = 2'd0; intf.wdata = 32'hFF;
        cycle();
        idle_inputs();
        intf.cpu_ie = 1'b1;
        intf.irq[3] = 1'b1;
        cycle();
        cycle();
        intf.irq[3] = 1'b0;
        cycle();
        #1;
        check("d1_req", 64'(intf.req), 64'd1);
        check("d1_vec", 64'(intf.vec), 64'd7);
        intf.ack = 1'b1;
        cycle();
        intf.ack = 1'b0;
        intf.adr = 2'd3;
        #1;
        check("d1_busy", 64'(intf.rdata[31]), 64'd1);
        check("d1_top", 64'(intf.rdata[4:0]), 64'd3);
        check("d1_req0", 64'(intf.req), 64'd0);
        intf.adr = 2'd1;
        #1;
        check("d1_pend3", 64'(intf.rdata[3]), 64'd0);
        intf.irq[0] = 1'b1;
        intf.irq[1] = 1'b1;
        cycle();
        cycle();
        cycle();
        cycle();

        // Asynchronous reset between edges while a channel is in service.
        #3;
        rst = 1'b1;
        #1;
        check("arst_req", 64'(intf.req), 64'd0);
        check("arst_vec", 64'(intf.vec), 64'(VB));
        for (int a = 0; a < 4; a++) begin
            intf.adr = 2'(a);
            #1;
            check("arst_rdata", 64'(intf.rdata), 64'd0);
        end
        m_reset();
        intf.irq = '0;
        @(negedge clk);
        rst = 1'b0;
        intf.rti = 1'b1;
        intf.adr = 2'd3;
        cycle();
        idle_inputs();
        intf.wr = 1'b1; intf.adr = 2'd0; intf.wdata = 32'hFF;
        cycle();

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NIRQ; i++)
                if ($urandom_range(7) == 0) intf.irq[i] = ~intf.irq[i];
            intf.cpu_ie = $urandom_range(9) != 0;
            intf.ack    = 1'($urandom_range(1));
            intf.rti    = $urandom_range(5) == 0;
            intf.wr     = $urandom_range(15) == 0;
            intf.rd     = 1'($urandom_range(1));
            intf.adr    = 2'($urandom_range(3));
            intf.wdata  = $urandom();
            if (intf.wr && intf.adr == 2'd0) intf.wdata = intf.wdata | 32'h0000_00F7;
            if (intf.wr && intf.adr == 2'd2) intf.wdata = intf.wdata & 32'h0000_0024;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/risc5_intctl.md
# risc5_intctl

Parametrised vectored interrupt controller for the RISC5 core; it generalises the core's single-line irq edge detector to NIRQ prioritised sources with nesting. It sits between the peripheral irq lines and the CPU control unit. It gives the CPU a request, a vector word address and the current priority level. Software programs it through a small memory-mapped register port on the I/O bus.

## Interface
- NIRQ, 8: number of sources, 1..32; index 0 is the highest priority.
- PCW, 22: vector/PC width in words.
- VEC_BASE, 1: word address of the channel 0 vector.
- VEC_STRIDE, 2: words between consecutive vectors.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- irq  in  NIRQ  raw peripheral requests; asynchronous to clk.
- cpu_ie  in  1  CPU global interrupt enable.
- ack  in  1  CPU accepts the current request this cycle.
- rti  in  1  CPU executes return-from-interrupt this cycle.
- req  out  1  interrupt request to the CPU.
- vec  out  PCW  vector word address for the current request.
- wr, rd  in  1  register write/read strobes.
- adr  in  2  register select.
- wdata  in  32  write data.
- rdata  out  32  read data; combinational, zero-extended.

## Operation
- Input path: a 2-flop synchroniser (s1, s2) feeds a history flop (s3). edge[i] = s2[i] & ~s3[i].
- Per-channel MODE bit: 0 = rising edge, 1 = level.
  - Edge mode: pend[i] sets on edge[i]. It clears on ack of channel i or on a write-1 to PEND. If set and clear happen in the same cycle, set wins.
  - Level mode: pend[i] = s2[i] combinationally. Writes and ack have no effect on it.
- ISR (in-service vector, NIRQ bits); `top` = lowest index set in ISR.
- Eligible set: elig = pend & EN & {channels with index < top}. When ISR is empty, every channel with index < NIRQ qualifies.
- id = lowest set index of elig.
- req = cpu_ie & |elig.
- vec = VEC_BASE + id*VEC_STRIDE, truncated to PCW bits; vec wraps modulo 2^PCW.
- ack with req=1: sets ISR[id] and clears pend[id] if channel id is in edge mode. ack with req=0 is ignored.
- rti clears ISR[top]; rti with ISR empty is ignored.
- rti and ack in the same cycle: the rti clear is applied first, then the ack set. id/elig are still computed from the pre-edge state.
- Registers:
  - 0 EN (r/w, bits NIRQ-1:0).
  - 1 PEND (read; write-1-to-clear).
  - 2 MODE (r/w).
  - 3 STAT (read only): bit31 = |ISR, bits 4:0 = top, bits 12:8 = id, bit16 = req.
  - Bits at or above NIRQ read 0 and ignore writes. A write to STAT has no effect.
- Reset clears s1, s2, s3, pend, ISR, EN and MODE. All outputs then read 0: req=0, vec=VEC_BASE, rdata=0.

## Timing
- irq rising before edge e1 gives s1=1 after e1 and s2=1 after e2. edge is then true, so pend=1 after e3. req rises after e3 if EN and cpu_ie are set (latency 3 clocks).
- Level mode: req follows irq with 2-clock latency, both rising and falling.
- An irq pulse narrower than one clock may be missed; sources hold irq for at least 2 clocks.
- ack/rti take effect at the edge where they are sampled. req/vec reflect the new state in the following cycle.
- Register writes take effect at the edge. rdata is valid in the same cycle as rd/adr; it is a function of state and is not gated by rd.
- A new edge on a channel that is already pending is absorbed: there is no counting.
- rst asserted mid-service drops req immediately and clears ISR; a later rti is ignored.

## Test plan
- NIRQ=8, EN=0xFF, edge mode; pulse irq[3] high for 2 clocks -> req=1 three clocks later, vec=1+3*2=7; ack -> pend[3]=0, STAT bit31=1 with top=3, req=0.
- Channel 3 in service; raise irq[5] and irq[1] together -> req for id=1 only, vec=3; ack -> ISR=0x0A. rti -> ISR=0x08; a second rti -> ISR=0; req then reasserts for 5, vec=11.
- Level mode on channel 2: hold irq[2] -> PEND bit2=1; write PEND=0x04 -> bit stays 1. Drop irq -> bit clears 2 clocks later.
- A new edge arrives on channel 4 in the same cycle as a write-1-clear of PEND bit4 -> pend[4]=1 afterwards; likewise for ack of channel 4.
- cpu_ie=0 with pend=0x01, EN=0x01 -> req=0 and STAT bit16=0; set cpu_ie=1 -> req=1 the same cycle; ack with req=0 changes nothing.
- Assert rst asynchronously between edges with ISR=0x10 and pend=0x03 -> req, ISR, pend, EN and MODE are all 0 immediately, vec=1 (VEC_BASE).
